// File: rtl/iocntl_pkg.sv
// Shared line/word definitions for iocntl and its line-read clients.
package iocntl_pkg;
    localparam int LINE_WORDS     = 8;
    localparam int WORD_BITS      = 16;
    localparam int LINE_ADDR_BITS = 28;

    typedef logic [WORD_BITS-1:0]      word_t;
    typedef word_t [0:LINE_WORDS-1]    line_t;
    typedef logic [LINE_ADDR_BITS-1:0] addr_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} ls_state_e;
endpackage

// File: rtl/line_fifo.sv
// Line-wide FIFO with power-of-two depth; count is exposed for credit accounting.
import iocntl_pkg::*;

module line_fifo #(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  line_t         din,
    output line_t         head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    line_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clock) disable iff (!reset_n) push |-> !full);
`endif
endmodule

// File: rtl/line_streamer.sv
// Issues sequential line reads under credit control and serialises the
// buffered lines into a 16-bit valid/ready word stream.
import iocntl_pkg::*;

module line_streamer #(
    parameter int FIFO_LINES = 2,
    parameter int CNT_BITS   = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cfg_start,
    input  addr_t               cfg_base,
    input  logic [CNT_BITS-1:0] cfg_lines,
    output logic                busy,
    output logic                done,
    output addr_t               rd_addr,
    output logic                rd_req,
    input  logic                rd_gnt,
    input  logic                rd_valid,
    input  line_t               rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output word_t               out_data,
    output logic                out_last
);
    localparam int            OW      = $clog2(FIFO_LINES + 1);
    localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_LINES);

    ls_state_e           state, state_nxt;
    logic [CNT_BITS-1:0] lines_total, lines_issued, lines_popped, issued_nxt;
    logic [OW-1:0]       outstanding, outstanding_nxt, fifo_count, occ_nxt;
    logic [2:0]          idx;
    logic                grant, push, pop, word_xfer, credit_ok;
    logic                fifo_empty, fifo_full;
    line_t               head;

    assign grant     = rd_req && rd_gnt;
    // Returns with nothing outstanding (or outside RUN) are stale and dropped.
    assign push      = rd_valid && (state == ST_RUN) && (outstanding != '0) && !fifo_full;
    assign word_xfer = out_valid && out_ready;
    assign pop       = word_xfer && (idx == 3'd7);

    // Credits are judged on post-edge values so a grant and a return in the
    // same cycle net out correctly.
    assign outstanding_nxt = outstanding + OW'(grant) - OW'(push);
    assign occ_nxt         = fifo_count + OW'(push) - OW'(pop);
    assign issued_nxt      = lines_issued + CNT_BITS'(grant);
    assign credit_ok       = (outstanding_nxt + occ_nxt) < DEPTH_C;

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head[idx] : '0;
    assign out_last  = out_valid && (idx == 3'd7) && (lines_popped == lines_total - 1'b1);

    line_fifo #(.DEPTH(FIFO_LINES)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (rd_data),
        .head    (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:   if (cfg_start) state_nxt = (cfg_lines == '0) ? ST_FINISH : ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (word_xfer && out_last) state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr      <= '0;
            rd_req       <= 1'b0;
            lines_total  <= '0;
            lines_issued <= '0;
            lines_popped <= '0;
            outstanding  <= '0;
            idx          <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            case (state)
                ST_IDLE: if (cfg_start) begin
                    rd_addr      <= cfg_base;
                    lines_total  <= cfg_lines;
                    lines_issued <= '0;
                    lines_popped <= '0;
                    idx          <= '0;
                    rd_req       <= (cfg_lines != '0);
                end
                ST_RUN: begin
                    lines_issued <= issued_nxt;
                    if (grant) rd_addr <= rd_addr + 1'b1;
                    // Request is held untouched until iocntl grants it.
                    if (!rd_req || rd_gnt)
                        rd_req <= (issued_nxt < lines_total) && credit_ok;
                    if (word_xfer) idx <= idx + 3'd1;
                    if (pop) lines_popped <= lines_popped + 1'b1;
                end
                default: rd_req <= 1'b0;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_stale_return: assert property (@(posedge clock) disable iff (!reset_n)
        rd_valid |-> (state == ST_RUN && outstanding != '0));
`endif
endmodule

// File: tb/tb_line_streamer.sv
// Scoreboarded bench: iocntl RAM model with random grant/return timing,
// expected word stream derived from base/count, monitor compares on handshakes.
import iocntl_pkg::*;

module tb_line_streamer;
    localparam int FL = 2;
    localparam int CB = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_start = 1'b0;
    addr_t         cfg_base = '0;
    logic [CB-1:0] cfg_lines = '0;
    logic          busy, done, rd_req, out_valid, out_last;
    logic          rd_gnt = 1'b0, rd_valid = 1'b0, out_ready = 1'b0;
    addr_t         rd_addr;
    line_t         rd_data = '0;
    word_t         out_data;

    always #5 clock = ~clock;

    line_streamer #(.FIFO_LINES(FL), .CNT_BITS(CB)) dut (
        .clock(clock), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_base(cfg_base),
        .cfg_lines(cfg_lines), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_req(rd_req),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM contents seen through iocntl: a fixed hash of line address and word index.
    function automatic word_t mem_word(input addr_t a, input int w);
        logic [31:0] h;
        h = {4'h0, a} * 32'h0000_9E37 + 32'(w) * 32'h0000_0101;
        return h[23:8] ^ h[15:0];
    endfunction

    typedef struct { word_t d; logic last; } exp_t;
    typedef struct { int due; addr_t a; } ret_t;
    exp_t  exp_q[$];
    addr_t exp_addr_q[$];
    ret_t  ret_q[$];

    // ---------------- iocntl model ----------------
    int    cyc = 0, gnt_max = 0, gnt_wait = 0, grants = 0, last_due = 0;
    logic  pending = 1'b0, prev_hold = 1'b0;
    addr_t prev_addr = '0;

    always begin : iocntl_model
        int lat;
        @(posedge clock); #1;
        cyc++;
        rd_valid = 1'b0;
        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            rd_valid = 1'b1;
            for (int w = 0; w < 8; w++) rd_data[w] = mem_word(ret_q[0].a, w);
            void'(ret_q.pop_front());
        end
        rd_gnt = 1'b0;
        if (!reset_n) begin
            pending   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && rd_req) chk("addr_hold", 32'(rd_addr), 32'(prev_addr));
            if (rd_req && !pending) begin
                pending  = 1'b1;
                gnt_wait = $urandom_range(gnt_max, 0);
            end
            if (pending) begin
                if (gnt_wait == 0) begin
                    rd_gnt  = 1'b1;
                    pending = 1'b0;
                    grants++;
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_grant", 32'(rd_addr), 32'hFFFF_FFFF);
                    end else begin
                        chk("rd_addr", 32'(rd_addr), 32'(exp_addr_q.pop_front()));
                    end
                    lat      = $urandom_range(4, 1);
                    last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                    ret_q.push_back('{due: last_due, a: rd_addr});
                    chk("outstanding_le_depth", 32'(ret_q.size() <= FL), 32'd1);
                end else begin
                    gnt_wait--;
                end
            end
            prev_hold = rd_req && !rd_gnt;
            prev_addr = rd_addr;
        end
    end

    // ---------------- consumer ready ----------------
    int rmode = 1;
    always begin
        @(posedge clock); #1;
        case (rmode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(1, 0));
        endcase
    end

    // ---------------- monitor ----------------
    int    acc = 0, done_cnt = 0;
    logic  done_due = 1'b0, zero_due = 1'b0, prev_stall = 1'b0;
    word_t prev_data = '0;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset_n) begin
            prev_stall = 1'b0;
            done_due   = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (done_due) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_at_done", 32'(busy), 32'd0);
            end else if (done && !zero_due) begin
                chk("spurious_done", 32'(done), 32'd0);
            end
            if (done) done_cnt++;
            done_due = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_last", 32'(out_last), 32'(e.last));
                    if (e.last) done_due = 1'b1;
                end
                acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input addr_t base, input int n);
        for (int k = 0; k < n; k++) begin
            addr_t a;
            a = base + addr_t'(k);
            exp_addr_q.push_back(a);
            for (int w = 0; w < 8; w++)
                exp_q.push_back('{d: mem_word(a, w), last: (k == n - 1 && w == 7)});
        end
        @(posedge clock); #1;
        cfg_base  = base;
        cfg_lines = CB'(n);
        cfg_start = 1'b1;
        @(posedge clock); #1;
        cfg_start = 1'b0;
    endtask

    task automatic start_chk(input addr_t base, input int n);
        pulse_start(base, n);
        @(negedge clock);
        chk("req_latency", 32'(rd_req), 32'd1);
        chk("first_addr", 32'(rd_addr), 32'(base));
        chk("busy_running", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clock);
        chk({name, "_done_seen"}, 32'(done_cnt > d0), 32'd1);
        @(negedge clock);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_addrs_left"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_rd_req"}, 32'(rd_req), 32'd0);
        chk({name, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_out_last"}, 32'(out_last), 32'd0);
        chk({name, "_out_data"}, 32'(out_data), 32'd0);
    endtask

    initial begin
        int g0, a0;
        repeat (3) @(posedge clock);
        #2;
        chk_reset_outputs("por");
        reset_n = 1'b1;

        // three lines, always ready, immediate grants
        gnt_max = 0; rmode = 1;
        start_chk(28'h0000100, 3);
        wait_done("basic", 400);

        // zero-length transfer
        zero_due = 1'b1;
        g0 = grants;
        pulse_start(28'h0000500, 0);
        @(negedge clock);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_req", 32'(rd_req), 32'd0);
        @(negedge clock);
        chk("zero_done_once", 32'(done), 32'd0);
        repeat (4) @(negedge clock);
        chk("zero_no_grants", 32'(grants - g0), 32'd0);
        zero_due = 1'b0;

        // address wrap
        start_chk(28'hFFFFFFF, 2);
        wait_done("wrap", 400);

        // consumer stalled: issue stops at FIFO depth
        rmode = 0;
        g0 = grants;
        start_chk(28'h0000400, 6);
        repeat (40) @(negedge clock);
        chk("stall_grants", 32'(grants - g0), 32'(FL));
        chk("stall_req_low", 32'(rd_req), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        rmode = 1;
        wait_done("stall", 800);

        // random grant delay and consumer backpressure
        gnt_max = 5; rmode = 2;
        start_chk(addr_t'($urandom()), 100);
        wait_done("random", 8000);

        // reset mid-transfer, then a clean one-line transfer
        gnt_max = 0; rmode = 1;
        a0 = acc;
        start_chk(28'h0000300, 4);
        for (int i = 0; i < 400 && acc < a0 + 10; i++) @(negedge clock);
        chk("reach_word10", 32'(acc - a0 >= 10), 32'd1);
        #2;
        reset_n = 1'b0;
        ret_q.delete();
        exp_q.delete();
        exp_addr_q.delete();
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        start_chk(28'h0000020, 1);
        wait_done("post_reset", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/line_streamer.md
Name: line_streamer

Overview:
- Read-side DMA client sitting directly upstream of iocntl on its line read interface.
- Given a base line address and a line count, it issues sequential line reads to iocntl and buffers the returned 8x16-bit lines.
- It serialises the lines into a 16-bit valid/ready word stream for compute consumers.
- Credit-based issue keeps buffer space reserved for every outstanding read, because the iocntl read return has no backpressure.

Parameters:
- FIFO_LINES, 2: line buffer depth, which is also the maximum outstanding-plus-buffered lines; legal values are 2 to 8, power of two.
- CNT_BITS, 16: width of the line-count configuration.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle start pulse; sampled only in IDLE
- cfg_base  in  28  first line address
- cfg_lines  in  CNT_BITS  number of lines to stream
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the final word is accepted
- rd_addr  out  28  line address to iocntl
- rd_req  out  1  read request to iocntl
- rd_gnt  in  1  iocntl accepts the request this cycle
- rd_valid  in  1  one-cycle return strobe from iocntl
- rd_data  in  16 x [0:7]  returned line; rd_data[0] is the lowest word
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer ready
- out_data  out  16  stream word
- out_last  out  1  marks the final word of the final line

Behaviour:
- Reset values: busy=0, done=0, rd_req=0, rd_addr=0, out_valid=0, out_last=0, out_data=0. All counters and the FIFO are cleared.
- Reset mid-operation aborts the transfer immediately. No done is produced. iocntl shares the reset, so no stale returns are expected.
- States:
  - IDLE: on cfg_start, latch cfg_base and cfg_lines and go to RUN; busy=1 from the next cycle. If cfg_lines=0, go to FINISH instead (no reads issued).
  - RUN: normal streaming. When the final word is accepted (out_valid && out_ready && out_last), go to FINISH.
  - FINISH: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- cfg_start while not in IDLE is ignored.
- Issue rule:
  - rd_req=1 in RUN while lines_issued < lines_total and credits > 0.
  - credits = FIFO_LINES - (outstanding + fifo_occupancy).
  - rd_req and rd_addr are registered and held stable until the handshake rd_req && rd_gnt.
  - On the handshake: rd_addr increments by 1 (modulo 2^28; wrap from 0xFFFFFFF to 0x0000000 is legal) and lines_issued increments.
- Latency: cfg_start in cycle t puts rd_req=1 in cycle t+1.
- Returns:
  - Each rd_valid pushes the line into line_fifo; outstanding decrements.
  - rd_valid while outstanding=0, or in IDLE, is dropped. Flag it with a simulation-only assertion.
- Simultaneous grant and return in the same cycle: outstanding is unchanged, occupancy +1, and the credit arithmetic stays consistent.
- Serialiser:
  - A 3-bit word index runs over the FIFO head line. out_data = head[idx].
  - out_valid = FIFO not empty.
  - Each handshake increments idx. At idx=7 the head is popped and idx returns to 0, which frees one credit the next cycle.
  - out_data and out_valid are held stable while out_valid && !out_ready.
- out_last = out_valid && idx==7 && head is the final line (lines_popped == lines_total-1).
- Throughput: one word per cycle sustained when the iocntl return rate is at least one line per 8 cycles.
- cfg_lines is width CNT_BITS; the maximum transfer is 2^CNT_BITS-1 lines. Counters never overflow.

Decomposition:
- iocntl_pkg holds the shared definitions:
  - LINE_WORDS=8, WORD_BITS=16, LINE_ADDR_BITS=28.
  - typedef word_t as logic[15:0].
  - typedef line_t as word_t[0:7].
- iocntl imports the same package.
- One sub-module, line_fifo:
  - Parameterised depth, storing line_t, with push/pop/empty/full/count.
  - count feeds the credit calculation.
  - Push when full is an assertion failure.

Test Plan:
- Base 0x0000100, lines=3, iocntl behind the ram model, out_ready=1 → rd_addr sequence 0x100, 0x101, 0x102. 24 words emerge in order with rd_data[0] of each line first. out_last on word 24 only. done pulses one cycle after that word; busy=0 afterwards.
- lines=0 start → no rd_req; done is high the cycle after IDLE→FINISH; busy high for zero cycles.
- Base 0xFFFFFFF, lines=2 → rd_addr 0xFFFFFFF, then 0x0000000; data is correct.
- out_ready=0 held, lines=6, FIFO_LINES=2 → exactly 2 grants, then rd_req is deasserted. Releasing out_ready resumes issue; all 48 words arrive with no loss and out_data stays stable while stalled.
- Random rd_gnt delays (0–5 cycles) and random out_ready at 50% over 100 lines → output matches the scoreboard. rd_addr never changes while rd_req && !rd_gnt. Outstanding never exceeds FIFO_LINES.
- reset_n asserted mid-transfer at word 10 → all outputs at reset values asynchronously. A following start with base 0x20, lines=1 streams 8 words correctly.
